// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with EX/MEM output register, RV32M mul/div, branch redirect and flush
module ex_stage_pipe #(
  parameter int XLEN = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_I,
  input  logic            in_valid_I,
  output logic            in_ready_O,
  input  logic [3:0]      ALUctl_EX_I,
  input  logic            md_en_EX_I,
  input  logic            br_en_EX_I,
  input  logic            jal_EX_I,
  input  logic            jalr_EX_I,
  input  logic            ALUSrc_EX_I,
  input  logic [XLEN-1:0] pc_EX_I,
  input  logic [XLEN-1:0] imme_EX_I,
  input  logic [XLEN-1:0] Rd_data1_EX_I,
  input  logic [XLEN-1:0] Rd_data2_EX_I,
  output logic            out_valid_O,
  input  logic            out_ready_I,
  output logic [XLEN-1:0] result_EX_O,
  output logic [XLEN-1:0] Rd_data2_EX_O,
  output logic            redirect_O,
  output logic [XLEN-1:0] pc_new_EX_O
);
  localparam int SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] int_min = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [SW:0] cnt;
  logic [2:0] f3, op;
  logic [XLEN-1:0] a, b, alu_b, alu, sra, hi, lo, opd, ua, ub, md1, md_res, qr, pc4, jt, pcn, res1;
  logic [2*XLEN-1:0] fp, p, pn;
  logic [XLEN:0] msum, dr, dsub;
  logic neg, sa, sb, an, bn, taken, div_zero, ovf, iter, acc, done, free, redir, ge;
  assign f3 = ALUctl_EX_I[2:0];
  assign a = Rd_data1_EX_I;
  assign b = Rd_data2_EX_I;
  assign alu_b = ALUSrc_EX_I ? imme_EX_I : b;
  assign free = !out_valid_O || out_ready_I;
  assign in_ready_O = state == IDLE && free && !flush_I;
  assign acc = in_valid_I && in_ready_O;
  assign done = state == BUSY && cnt == '0 && free;
  assign sra = $signed(a) >>> alu_b[SW-1:0];
  always_comb begin
    case (f3)
      3'b000: alu = ALUctl_EX_I[3] ? a - alu_b : a + alu_b;
      3'b001: alu = a << alu_b[SW-1:0];
      3'b010: alu = XLEN'($signed(a) < $signed(alu_b));
      3'b011: alu = XLEN'(a < alu_b);
      3'b100: alu = a ^ alu_b;
      3'b101: alu = ALUctl_EX_I[3] ? sra : a >> alu_b[SW-1:0];
      3'b110: alu = a | alu_b;
      default: alu = a & alu_b;
    endcase
  end
  assign taken = (f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b) ^ f3[0];
  assign pc4 = pc_EX_I + XLEN'(4);
  assign jt = a + imme_EX_I;
  assign redir = jal_EX_I || jalr_EX_I || (br_en_EX_I && taken);
  assign pcn = jalr_EX_I ? jt & ~XLEN'(1) : redir ? pc_EX_I + imme_EX_I : pc4;
  // operand signedness: div/rem signed unless func3[0]; mulh both, mulhsu rs1 only
  assign sa = f3[2] ? !f3[0] : f3[1] ^ f3[0];
  assign sb = f3[2] ? !f3[0] : f3[1:0] == 2'b01;
  assign an = sa && a[XLEN-1];
  assign bn = sb && b[XLEN-1];
  assign ua = an ? -a : a;
  assign ub = bn ? -b : b;
  assign div_zero = b == '0;
  assign ovf = sa && a == int_min && b == '1;
  assign fp = {{XLEN{an}}, a} * {{XLEN{bn}}, b};
  assign md1 = f3[2] ? (div_zero ? (f3[1] ? a : '1) : (f3[1] ? '0 : a))
                     : (f3[1:0] == 2'b00 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN]);
  assign iter = md_en_EX_I && (f3[2] ? !(div_zero || ovf) : FAST_MUL == 0);
  assign res1 = (jal_EX_I || jalr_EX_I) ? pc4 : md_en_EX_I ? md1 : alu;
  assign msum = {1'b0, hi} + {1'b0, opd & {XLEN{lo[0]}}};
  assign dr = {hi, lo[XLEN-1]};
  assign dsub = dr - {1'b0, opd};
  assign ge = !dsub[XLEN];
  assign p = {hi, lo};
  assign pn = neg ? -p : p;
  assign qr = op[1] ? hi : lo;
  assign md_res = op[2] ? (neg ? -qr : qr) : (op[1:0] == 2'b00 ? pn[XLEN-1:0] : pn[2*XLEN-1:XLEN]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      out_valid_O <= 1'b0;
      redirect_O <= 1'b0;
      result_EX_O <= '0;
      pc_new_EX_O <= '0;
      Rd_data2_EX_O <= '0;
      hi <= '0;
      lo <= '0;
      opd <= '0;
      op <= '0;
      neg <= 1'b0;
    end else if (flush_I) begin
      state <= IDLE;
      cnt <= '0;
      out_valid_O <= 1'b0;
      redirect_O <= 1'b0;
    end else begin
      if (acc && iter) begin
        state <= BUSY;
        cnt <= (SW+1)'(XLEN);
        hi <= '0;
        lo <= ua;
        opd <= ub;
        op <= f3;
        neg <= (f3[2] && f3[1]) ? an : an ^ bn;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - (SW+1)'(1);
        hi <= op[2] ? (ge ? dsub[XLEN-1:0] : dr[XLEN-1:0]) : msum[XLEN:1];
        lo <= op[2] ? {lo[XLEN-2:0], ge} : {msum[0], lo[XLEN-1:1]};
      end else if (done) begin
        state <= IDLE;
      end
      if (acc && !iter) begin
        out_valid_O <= 1'b1;
        result_EX_O <= res1;
        redirect_O <= redir;
        pc_new_EX_O <= pcn;
        Rd_data2_EX_O <= b;
      end else if (done) begin
        out_valid_O <= 1'b1;
        result_EX_O <= md_res;
        redirect_O <= 1'b0;
      end else if (out_ready_I) begin
        out_valid_O <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed vectors with a scoreboard queue and a decoupled output monitor
module tb_ex_stage_pipe;
  localparam logic [4:0] ALU = 5'b00000, ALUI = 5'b00001, JALR = 5'b00010, JAL = 5'b00100, BR = 5'b01000, MD = 5'b10000;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, f_valid = 1'b0, out_ready = 1'b1, f_out_ready = 1'b1;
  logic [3:0] ctl = '0;
  logic md = 1'b0, br = 1'b0, jal = 1'b0, jalr = 1'b0, src = 1'b0;
  logic [31:0] pc = '0, imm = '0, r1 = '0, r2 = '0;
  logic in_ready, out_valid, redirect, f_ready, f_out_valid, f_redirect, seen, rdy;
  logic [31:0] result, rd2_o, pc_new, f_result, f_rd2, f_pc_new;
  int checks = 0, errors = 0, last_wait, k;
  typedef struct {
    string name;
    logic [31:0] res;
    logic redir;
    logic [31:0] pcn;
    logic [1:0] chk;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;
  always #5 clk = ~clk;
  ex_stage_pipe #(.XLEN(32), .FAST_MUL(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush_I(flush), .in_valid_I(in_valid), .in_ready_O(in_ready),
    .ALUctl_EX_I(ctl), .md_en_EX_I(md), .br_en_EX_I(br), .jal_EX_I(jal), .jalr_EX_I(jalr),
    .ALUSrc_EX_I(src), .pc_EX_I(pc), .imme_EX_I(imm), .Rd_data1_EX_I(r1), .Rd_data2_EX_I(r2),
    .out_valid_O(out_valid), .out_ready_I(out_ready), .result_EX_O(result), .Rd_data2_EX_O(rd2_o),
    .redirect_O(redirect), .pc_new_EX_O(pc_new)
  );
  ex_stage_pipe #(.XLEN(32), .FAST_MUL(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .flush_I(flush), .in_valid_I(f_valid), .in_ready_O(f_ready),
    .ALUctl_EX_I(ctl), .md_en_EX_I(md), .br_en_EX_I(br), .jal_EX_I(jal), .jalr_EX_I(jalr),
    .ALUSrc_EX_I(src), .pc_EX_I(pc), .imme_EX_I(imm), .Rd_data1_EX_I(r1), .Rd_data2_EX_I(r2),
    .out_valid_O(f_out_valid), .out_ready_I(f_out_ready), .result_EX_O(f_result), .Rd_data2_EX_O(f_rd2),
    .redirect_O(f_redirect), .pc_new_EX_O(f_pc_new)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h with no expected entry", result);
      end else begin
        e_m = sb.pop_front();
        if (e_m.chk[1]) check({e_m.name, "_result"}, result, e_m.res);
        check({e_m.name, "_redirect"}, 32'(redirect), 32'(e_m.redir));
        if (e_m.chk[0]) check({e_m.name, "_pc_new"}, pc_new, e_m.pcn);
      end
    end
  end
  task automatic issue(input logic [3:0] c, input logic [4:0] f, input logic [31:0] p, i, a, d);
    ctl = c;
    {md, br, jal, jalr, src} = f;
    pc = p;
    imm = i;
    r1 = a;
    r2 = d;
    in_valid = 1'b1;
    #1;
    last_wait = 0;
    while (!in_ready && last_wait < 200) begin
      @(posedge clk);
      #2;
      last_wait++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic run(input string n, input logic [3:0] c, input logic [4:0] f, input logic [31:0] p, i, a, d,
                     input logic [31:0] res, input logic rd, input logic [31:0] pnew, input logic [1:0] chk);
    sb.push_back('{n, res, rd, pnew, chk});
    issue(c, f, p, i, a, d);
  endtask
  task automatic wait_valid(output int cyc, output logic rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      rdy_seen |= in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_pc_new", pc_new, 32'd0);
    check("rst_rd2", rd2_o, 32'd0);
    @(posedge clk);
    #1;
    run("add", 4'h0, ALU, 0, 0, 5, 7, 12, 1'b0, 0, 2'b10);
    check("add_wait", last_wait, 0);
    run("sub", 4'h8, ALU, 0, 0, 3, 5, 32'hFFFFFFFE, 1'b0, 0, 2'b10);
    check("sub_b2b_wait", last_wait, 0);
    run("addi", 4'h0, ALUI, 0, 32'hFFFFFFFD, 10, 99, 7, 1'b0, 0, 2'b10);
    run("sll", 4'h1, ALU, 0, 0, 1, 4, 16, 1'b0, 0, 2'b10);
    run("slt", 4'h2, ALU, 0, 0, 32'hFFFFFFFF, 1, 1, 1'b0, 0, 2'b10);
    run("sltu", 4'h3, ALU, 0, 0, 32'hFFFFFFFF, 1, 0, 1'b0, 0, 2'b10);
    run("xor", 4'h4, ALU, 0, 0, 32'hF0, 32'hFF, 32'h0F, 1'b0, 0, 2'b10);
    run("srl", 4'h5, ALU, 0, 0, 32'h80000000, 4, 32'h08000000, 1'b0, 0, 2'b10);
    run("sra", 4'hD, ALU, 0, 0, 32'h80000000, 4, 32'hF8000000, 1'b0, 0, 2'b10);
    run("or", 4'h6, ALU, 0, 0, 32'hF0, 32'h0F, 32'hFF, 1'b0, 0, 2'b10);
    run("and", 4'h7, ALU, 0, 0, 32'hF0, 32'h3C, 32'h30, 1'b0, 0, 2'b10);
    run("bne_taken", 4'h1, BR, 32'h100, 32'h20, 1, 2, 0, 1'b1, 32'h120, 2'b01);
    run("bne_not", 4'h1, BR, 32'h100, 32'h20, 2, 2, 0, 1'b0, 32'h104, 2'b01);
    run("blt_taken", 4'h4, BR, 32'h300, 32'h10, 32'hFFFFFFFF, 1, 0, 1'b1, 32'h310, 2'b01);
    run("bgeu_taken", 4'h7, BR, 32'h300, 32'h40, 32'hFFFFFFFF, 1, 0, 1'b1, 32'h340, 2'b01);
    run("jalr", 4'h0, JALR, 32'h40, 4, 32'h1001, 0, 32'h44, 1'b1, 32'h1004, 2'b11);
    run("jal", 4'h0, JAL, 32'h200, 32'h80, 0, 0, 32'h204, 1'b1, 32'h280, 2'b11);
    idle(2);
    run("divu", 4'h5, MD, 0, 0, 100, 7, 14, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    check("divu_latency", k, 33);
    check("divu_in_ready_low", 32'(rdy), 32'd0);
    idle(2);
    run("div_ovf", 4'h4, MD, 0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 0, 2'b10);
    check("div_ovf_1cycle", 32'(out_valid), 32'd1);
    idle(2);
    run("rem_zero", 4'h6, MD, 0, 0, 9, 0, 9, 1'b0, 0, 2'b10);
    check("rem_zero_1cycle", 32'(out_valid), 32'd1);
    run("divu_zero", 4'h5, MD, 0, 0, 9, 0, 32'hFFFFFFFF, 1'b0, 0, 2'b10);
    run("div_neg", 4'h4, MD, 0, 0, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    run("rem_neg", 4'h6, MD, 0, 0, 32'hFFFFFFF9, 2, 32'hFFFFFFFF, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    idle(2);
    run("mulh", 4'h1, MD, 0, 0, 32'hFFFFFFFE, 3, 32'hFFFFFFFF, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    check("mulh_latency", k, 33);
    run("mul", 4'h0, MD, 0, 0, 32'hFFFFFFFE, 3, 32'hFFFFFFFA, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    run("mulhsu", 4'h2, MD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    run("mulhu", 4'h3, MD, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0, 2'b10);
    wait_valid(k, rdy);
    idle(2);
    ctl = 4'h1;
    {md, br, jal, jalr, src} = MD;
    r1 = 32'hFFFFFFFE;
    r2 = 3;
    f_valid = 1'b1;
    #1;
    check("fast_ready", 32'(f_ready), 32'd1);
    @(posedge clk);
    #1;
    f_valid = 1'b0;
    check("fast_mulh_1cycle", 32'(f_out_valid), 32'd1);
    check("fast_mulh_result", f_result, 32'hFFFFFFFF);
    idle(2);
    out_ready = 1'b0;
    run("bp_add", 4'h0, ALU, 0, 0, 1, 1, 2, 1'b0, 0, 2'b10);
    check("bp_valid", 32'(out_valid), 32'd1);
    ctl = 4'h8;
    {md, br, jal, jalr, src} = ALU;
    r1 = 10;
    r2 = 3;
    in_valid = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      seen |= in_ready || !out_valid || result !== 32'd2 || redirect;
    end
    check("bp_hold_stable", 32'(seen), 32'd0);
    sb.push_back('{"bp_sub", 7, 1'b0, 0, 2'b10});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_release_accept", 32'(out_valid), 32'd1);
    idle(2);
    issue(4'h5, MD, 0, 0, 100, 7);
    repeat (9) @(posedge clk);
    #1;
    ctl = 4'h0;
    {md, br, jal, jalr, src} = ALU;
    r1 = 2;
    r2 = 3;
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_blocks_accept", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_clears_valid", 32'(out_valid), 32'd0);
    #1;
    check("post_flush_ready", 32'(in_ready), 32'd1);
    sb.push_back('{"post_flush_add", 5, 1'b0, 0, 2'b10});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_flush_accept", 32'(out_valid), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("flushed_div_silent", 32'(seen), 32'd0);
    issue(4'h5, MD, 0, 0, 100, 7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy_valid", 32'(out_valid), 32'd0);
    check("rst_busy_ready", 32'(in_ready), 32'd1);
    check("rst_busy_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("rst_div_silent", 32'(seen), 32'd0);
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
